// File: rtl/iz_loader_pkg.sv
// Shared types and constants for the Izhikevich parameter loader:
// FSM states, frame header, timeout length and reset-default parameters.
package iz_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CKSUM
  } state_t;

  localparam logic [7:0]  HEADER         = 8'hA5;
  localparam int          TIMEOUT_CYCLES = 1024;
  localparam int          PAYLOAD_LEN    = 8;
  localparam int          NUM_PARAMS     = PAYLOAD_LEN / 2;

  // Regular-spiking neuron, fixed-point scale 64
  localparam logic [15:0] DEF_A = 16'h0001;
  localparam logic [15:0] DEF_B = 16'h000D;
  localparam logic [15:0] DEF_C = 16'hEFC0;
  localparam logic [15:0] DEF_D = 16'h0200;

  function automatic logic [15:0] default_param(input int idx);
    case (idx)
      0:       return DEF_A;
      1:       return DEF_B;
      2:       return DEF_C;
      default: return DEF_D;
    endcase
  endfunction

endpackage

// File: rtl/iz_param_loader_if.sv
// Configuration byte bus in, committed neuron parameters and status out.
// The loader takes the slave modport; the configuration host takes master.
interface iz_param_loader_if;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic [15:0] param_a;
  logic [15:0] param_b;
  logic [15:0] param_c;
  logic [15:0] param_d;
  logic        params_ready;
  logic        busy;
  logic        load_error;
  logic [7:0]  load_count;

  modport master (
    output cfg_data, cfg_valid,
    input  param_a, param_b, param_c, param_d,
    input  params_ready, busy, load_error, load_count
  );

  modport slave (
    input  cfg_data, cfg_valid,
    output param_a, param_b, param_c, param_d,
    output params_ready, busy, load_error, load_count
  );
endinterface

// File: rtl/iz_loader_timer.sv
// Inter-byte idle counter; expired flags the idle edge on which the count
// would reach CYCLES-1, so the FSM aborts on that same edge.
import iz_loader_pkg::*;

module iz_loader_timer #(
  parameter int CYCLES = TIMEOUT_CYCLES,
  localparam int W     = $clog2(CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear || !run) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = run && !clear && (count_reg == W'(CYCLES - 2));

endmodule

// File: rtl/iz_param_loader.sv
// Framed configuration loader: HEADER, 8 payload bytes, XOR checksum;
// parameters are committed atomically only when the checksum matches.
import iz_loader_pkg::*;

module iz_param_loader (
  input  logic             clk,
  input  logic             reset_n,
  iz_param_loader_if.slave bus
);

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [7:0]  xor_reg;
  logic [7:0]  shadow_reg  [PAYLOAD_LEN];
  logic [15:0] shadow_word [NUM_PARAMS];
  logic [15:0] param_reg   [NUM_PARAMS];
  logic        valid_set_reg;
  logic        params_ready_reg;
  logic        busy_reg;
  logic        load_error_reg;
  logic [7:0]  load_count_reg;
  logic        timer_run;
  logic        timer_expired;

  assign timer_run = (state_reg != IDLE);

  iz_loader_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.cfg_valid),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Payload is big-endian per parameter: a_hi a_lo b_hi b_lo ...
  generate
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_word
      assign shadow_word[gi] = {shadow_reg[2*gi], shadow_reg[2*gi+1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      xor_reg          <= '0;
      valid_set_reg    <= 1'b0;
      params_ready_reg <= 1'b0;
      busy_reg         <= 1'b0;
      load_error_reg   <= 1'b0;
      load_count_reg   <= '0;
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow_reg[i] <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) param_reg[i] <= default_param(i);
    end else begin
      load_error_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.cfg_valid && bus.cfg_data == HEADER) begin
            state_reg        <= PAYLOAD;
            idx_reg          <= '0;
            xor_reg          <= HEADER;
            params_ready_reg <= 1'b0;
            busy_reg         <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (bus.cfg_valid) begin
            shadow_reg[idx_reg] <= bus.cfg_data;
            xor_reg             <= xor_reg ^ bus.cfg_data;
            idx_reg             <= idx_reg + 3'd1;
            if (idx_reg == 3'(PAYLOAD_LEN - 1)) state_reg <= CKSUM;
          end else if (timer_expired) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            load_error_reg   <= 1'b1;
            params_ready_reg <= valid_set_reg;
          end
        end
        CKSUM: begin
          if (bus.cfg_valid) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            if (bus.cfg_data == xor_reg) begin
              for (int i = 0; i < NUM_PARAMS; i++) param_reg[i] <= shadow_word[i];
              valid_set_reg    <= 1'b1;
              params_ready_reg <= 1'b1;
              load_count_reg   <= load_count_reg + 8'd1;
            end else begin
              load_error_reg   <= 1'b1;
              params_ready_reg <= valid_set_reg;
            end
          end else if (timer_expired) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            load_error_reg   <= 1'b1;
            params_ready_reg <= valid_set_reg;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.param_a      = param_reg[0];
  assign bus.param_b      = param_reg[1];
  assign bus.param_c      = param_reg[2];
  assign bus.param_d      = param_reg[3];
  assign bus.params_ready = params_ready_reg;
  assign bus.busy         = busy_reg;
  assign bus.load_error   = load_error_reg;
  assign bus.load_count   = load_count_reg;

endmodule

// File: tb/tb_iz_param_loader.sv
// Scoreboard bench for iz_param_loader: frame-level reference model pushes
// expected commit/error events, a negedge monitor pops and compares them.
module tb_iz_param_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  iz_param_loader_if bus();

  iz_param_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        err;
    logic [63:0] params;
    logic [7:0]  cnt;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: committed parameter set, validity, commit counter
  logic [15:0] m_p [4];
  logic        m_valid;
  logic [7:0]  m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p     = '{16'h0001, 16'h000D, 16'hEFC0, 16'h0200};
    m_valid = 1'b0;
    m_cnt   = 8'd0;
  endtask

  function automatic logic [63:0] m_pack();
    return {m_p[0], m_p[1], m_p[2], m_p[3]};
  endfunction

  function automatic logic [63:0] dut_params();
    return {bus.param_a, bus.param_b, bus.param_c, bus.param_d};
  endfunction

  // Monitor: any error pulse or change in load_count is an event to score
  logic [7:0] last_cnt = 8'd0;
  logic       mon_commit;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      last_cnt = 8'd0;
    end else begin
      mon_commit = (bus.load_count !== last_cnt);
      last_cnt   = bus.load_count;
      if (bus.load_error || mon_commit) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got err=%0b commit=%0b expected no event",
                   bus.load_error, mon_commit);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", {62'd0, bus.load_error, mon_commit}, {62'd0, mon_e.err, !mon_e.err});
          check("event_params", dut_params(), mon_e.params);
          check("event_load_count", bus.load_count, mon_e.cnt);
          check("event_params_ready", bus.params_ready, mon_e.ready);
          check("event_busy", bus.busy, 0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.cfg_data  = b;
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_payload(output logic [7:0] pl [8]);
    for (int i = 0; i < 8; i++)
      pl[i] = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
  endtask

  // mask 0 sends the correct checksum; nonzero corrupts it.
  // long_gap_at places a 1022-cycle gap before byte index (8 = checksum).
  task automatic send_frame(input logic [7:0] pl [8], input logic [7:0] mask,
                            input int max_gap, input int long_gap_at);
    logic [7:0] ck;
    exp_t       e;
    send_byte(8'hA5);
    check("hdr_busy", bus.busy, 1);
    check("hdr_params_ready", bus.params_ready, 0);
    ck = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      idle(i == long_gap_at ? 1022 : int'($urandom_range(0, max_gap)));
      send_byte(pl[i]);
      ck = ck ^ pl[i];
    end
    idle(long_gap_at == 8 ? 1022 : int'($urandom_range(0, max_gap)));
    if (mask == 8'd0) begin
      for (int k = 0; k < 4; k++) m_p[k] = {pl[2*k], pl[2*k+1]};
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      e.err   = 1'b0;
    end else begin
      e.err   = 1'b1;
    end
    e.params = m_pack();
    e.cnt    = m_cnt;
    e.ready  = m_valid;
    sb.push_back(e);
    send_byte(ck ^ mask);
  endtask

  // Header plus n payload bytes, then silence until the loader gives up
  task automatic timeout_frame(input int n_bytes);
    exp_t e;
    send_byte(8'hA5);
    for (int i = 0; i < n_bytes; i++) send_byte(8'($urandom_range(0, 255)));
    e.err    = 1'b1;
    e.params = m_pack();
    e.cnt    = m_cnt;
    e.ready  = m_valid;
    sb.push_back(e);
    idle(1022);
    check("pre_timeout_error", bus.load_error, 0);
    check("pre_timeout_busy", bus.busy, 1);
    idle(1);
    check("timeout_error", bus.load_error, 1);
    check("timeout_busy", bus.busy, 0);
    check("timeout_params_ready", bus.params_ready, m_valid);
    idle(1);
    check("timeout_error_pulse", bus.load_error, 0);
  endtask

  task automatic send_noise(input logic [7:0] b);
    send_byte(b);
    check("noise_busy", bus.busy, 0);
  endtask

  logic [7:0] pl [8];
  logic [7:0] nb;

  initial begin
    model_reset();
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    check("reset_params", dut_params(), 64'h0001_000D_EFC0_0200);
    check("reset_params_ready", bus.params_ready, 0);
    check("reset_load_count", bus.load_count, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_load_error", bus.load_error, 0);

    // Known-good frame, then the same frame with checksum 85
    pl = '{8'h00, 8'h01, 8'h00, 8'h0D, 8'hEF, 8'hC0, 8'h02, 8'h00};
    send_frame(pl, 8'h00, 0, -1);
    check("good_params", dut_params(), 64'h0001_000D_EFC0_0200);
    check("good_params_ready", bus.params_ready, 1);
    check("good_load_count", bus.load_count, 1);
    send_frame(pl, 8'h01, 0, -1);
    check("bad_params_kept", dut_params(), 64'h0001_000D_EFC0_0200);
    check("bad_params_ready", bus.params_ready, 1);

    send_noise(8'h00);
    send_noise(8'hFF);
    send_noise(8'h5A);

    pl = '{8'hA5, 8'hA5, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h80, 8'h01};
    send_frame(pl, 8'h00, 1, -1);
    check("a5_payload_params", dut_params(), 64'hA5A5_1234_A500_8001);

    timeout_frame(2);
    rand_payload(pl);
    send_frame(pl, 8'h00, 0, -1);
    timeout_frame(8);

    // A byte on the last permitted cycle is accepted
    rand_payload(pl);
    send_frame(pl, 8'h00, 0, 3);
    rand_payload(pl);
    send_frame(pl, 8'h00, 0, 8);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h3C;
        send_noise(nb);
      end
      rand_payload(pl);
      send_frame(pl, ($urandom_range(0, 9) < 3) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 2, -1);
    end

    // Asynchronous reset in the middle of a payload
    send_byte(8'hA5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midreset_params", dut_params(), 64'h0001_000D_EFC0_0200);
    check("midreset_busy", bus.busy, 0);
    check("midreset_params_ready", bus.params_ready, 0);
    check("midreset_load_count", bus.load_count, 0);
    check("midreset_sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int it = 0; it < 256; it++) begin
      rand_payload(pl);
      send_frame(pl, 8'h00, 1, -1);
    end
    check("wrap_load_count", bus.load_count, 0);
    check("wrap_params_ready", bus.params_ready, 1);
    check("wrap_params", dut_params(), m_pack());

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
